ir_cmd_scheduler: RTL

Sits between the IR NEC frame receiver and the game control logic. It captures each validated 32-bit frame and filters it by remote address and per-key holdoff. It maps the key code to a game command (FLAP/PAUSE/START/OTHER) and buffers commands in a 4-entry FIFO drained by the game FSM through a valid/ready handshake. START flushes pending commands so a restart is never preceded by stale flaps.

---
 rtl/ir_cmd_scheduler.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ir_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ir_cmd_scheduler
// Purpose  : Captures validated NEC IR frames, filters them by address,
//            unmapped key and per-key holdoff, maps keys to game commands,
//            and buffers them in a 4-entry FWFT FIFO. START flushes the FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ir_cmd_scheduler #(
    parameter logic [15:0] ADDR        = 16'hFF00,
    parameter bit          ADDR_CHECK  = 1'b1,
    parameter logic [7:0]  KEY_FLAP    = 8'h1A,
    parameter logic [7:0]  KEY_PAUSE   = 8'h16,
    parameter logic [7:0]  KEY_START   = 8'h12,
    parameter bit          PASS_OTHER  = 1'b0,
    parameter int unsigned HOLDOFF_CYC = 10000000
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iDATA_READY,
    input  logic [31:0] iDATA,
    output logic        oCMD_VALID,
    input  logic        iCMD_READY,
    output logic [1:0]  oCMD,
    output logic [7:0]  oKEY,
    output logic [2:0]  oLEVEL,
    output logic        oOVERFLOW,
    output logic        oREJECT,
    output logic [7:0]  oDROP_CNT
);

    localparam logic [23:0] HOLD_MAX = 24'(HOLDOFF_CYC);

    typedef enum logic [2:0] {
        S_WAIT  = 3'd0,
        S_CHECK = 3'd1,
        S_REJ   = 3'd2,
        S_FLUSH = 3'd3,
        S_PUSH  = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic        ready_prev;
    logic        new_frame;
    logic [23:0] frame;
    logic        pend;
    logic [23:0] pend_data;
    logic [7:0]  last_key;
    logic        last_valid;
    logic [23:0] hold_cnt;
    logic [9:0]  mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  level;
    logic        ovf_q;
    logic [7:0]  drop_cnt;

    logic [7:0]  key;
    logic        addr_ok, mapped, held;
    logic [1:0]  cmd_code;
    logic        full, pop, push_ok, push_drop, pend_drop;
    logic        unused_inv;

    // The inverted-key byte is already validated by the receiver.
    assign unused_inv = ^iDATA[31:24];

    assign new_frame = iDATA_READY & ~ready_prev;
    assign key       = frame[23:16];
    assign addr_ok   = !ADDR_CHECK || (frame[15:0] == ADDR);
    assign mapped    = (key == KEY_FLAP) || (key == KEY_PAUSE) || (key == KEY_START);
    assign held      = last_valid && (key == last_key) && (hold_cnt < HOLD_MAX);
    assign cmd_code  = (key == KEY_FLAP)  ? 2'd1 :
                       (key == KEY_PAUSE) ? 2'd2 :
                       (key == KEY_START) ? 2'd3 : 2'd0;

    // A pop during FLUSH is discarded so the flush always empties the FIFO.
    assign full      = (level == 3'd4);
    assign pop       = oCMD_VALID && iCMD_READY && (state != S_FLUSH);
    assign push_ok   = (state == S_PUSH) && (!full || pop);
    assign push_drop = (state == S_PUSH) && full && !pop;
    assign pend_drop = new_frame && pend && (state != S_WAIT);

    assign oCMD_VALID = (level != 3'd0);
    assign oCMD       = oCMD_VALID ? mem[rd_ptr][9:8] : 2'd0;
    assign oKEY       = oCMD_VALID ? mem[rd_ptr][7:0] : 8'd0;
    assign oLEVEL     = level;
    assign oREJECT    = (state == S_REJ);
    assign oOVERFLOW  = ovf_q;
    assign oDROP_CNT  = drop_cnt;

    // State register
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) state <= S_WAIT;
        else         state <= state_nxt;
    end

    // Next-state logic: classify the latched frame in CHECK
    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT:  if (new_frame || pend) state_nxt = S_CHECK;
            S_CHECK: begin
                if (!addr_ok || (!mapped && !PASS_OTHER) || held) state_nxt = S_REJ;
                else if (key == KEY_START)                        state_nxt = S_FLUSH;
                else                                              state_nxt = S_PUSH;
            end
            S_REJ:   state_nxt = S_WAIT;
            S_FLUSH: state_nxt = S_PUSH;
            S_PUSH:  state_nxt = S_WAIT;
            default: state_nxt = S_WAIT;
        endcase
    end

    // Frame capture and one-deep pending slot; previous-level register resets high
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            ready_prev <= 1'b1;
            frame      <= 24'd0;
            pend       <= 1'b0;
            pend_data  <= 24'd0;
        end else begin
            ready_prev <= iDATA_READY;
            if (state == S_WAIT) begin
                if (pend) begin
                    frame <= pend_data;
                    pend  <= new_frame;
                    if (new_frame) pend_data <= iDATA[23:0];
                end else if (new_frame) begin
                    frame <= iDATA[23:0];
                end
            end else if (new_frame && !pend) begin
                pend      <= 1'b1;
                pend_data <= iDATA[23:0];
            end
        end
    end

    // Holdoff tracking: restarted only by a successful write
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            last_key   <= 8'h00;
            last_valid <= 1'b0;
            hold_cnt   <= HOLD_MAX;
        end else if (push_ok) begin
            last_key   <= key;
            last_valid <= 1'b1;
            hold_cnt   <= 24'd0;
        end else if (hold_cnt < HOLD_MAX) begin
            hold_cnt   <= hold_cnt + 24'd1;
        end
    end

    // FIFO storage (contents need no reset; outputs are gated by level)
    always_ff @(posedge iCLK) begin
        if (push_ok) mem[wr_ptr] <= {cmd_code, key};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            level  <= 3'd0;
        end else if (state == S_FLUSH) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            level  <= 3'd0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 2'd1;
            if (pop)     rd_ptr <= rd_ptr + 2'd1;
            level <= level + 3'(push_ok) - 3'(pop);
        end
    end

    // Overflow pulse and saturating drop counter
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            ovf_q    <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            ovf_q <= push_drop || pend_drop;
            if ({1'b0, drop_cnt} + 9'(push_drop) + 9'(pend_drop) > 9'd255)
                drop_cnt <= 8'd255;
            else
                drop_cnt <= drop_cnt + 8'(push_drop) + 8'(pend_drop);
        end
    end

endmodule
`default_nettype wire
